// File: rtl/scr1_rst_seq.sv
// Reset sequencer: merges master reset with maskable requests, stretches the pulse,
// then releases N_DOM domains in index order. Optional cause capture: SCR1_RST_SEQ_CAUSE_EN.
module scr1_rst_seq #(
  parameter int N_SRC       = 2,
  parameter int N_DOM       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] rst_req_i,
  input  logic [N_SRC-1:0] rst_req_mask_i,
  output logic [N_DOM-1:0] dom_rst_n_o,
  output logic             rdc_qlfy_o,
  output logic             busy_o,
  input  logic             cause_clr_i,
  output logic [N_SRC:0]   cause_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam int IW = (N_DOM       > 1) ? $clog2(N_DOM)       : 1;

  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_DOM = IW'(N_DOM - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e           r_state;
  logic [HW-1:0]    r_hold_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [IW-1:0]    r_dom_idx;
  logic [N_DOM-1:0] r_dom_rst_n;
  logic             r_busy;
  logic             r_rdc_qlfy;

  logic [N_SRC-1:0] w_req_vec;
  logic             w_req;
  logic [IW-1:0]    w_idx_nxt;

  assign w_req_vec = rst_req_i & ~rst_req_mask_i;
  assign w_req     = |w_req_vec;
  assign w_idx_nxt = r_dom_idx + IW'(1);

  // A live request overrides every state: entry from RUN, abort from RELEASE,
  // and hold extension in ASSERT all collapse into the same reload.
  // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ASSERT;
      r_hold_cnt  <= HOLD_LD;
      r_gap_cnt   <= GAP_LD;
      r_dom_idx   <= '0;
      r_dom_rst_n <= '0;
      r_busy      <= 1'b1;
      r_rdc_qlfy  <= 1'b1;
    end else if (w_req) begin
      r_state     <= ST_ASSERT;
      r_hold_cnt  <= HOLD_LD;
      r_dom_rst_n <= '0;
      r_busy      <= 1'b1;
      r_rdc_qlfy  <= 1'b1;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (r_hold_cnt == '0) begin
            r_state     <= ST_RELEASE;
            r_dom_rst_n <= N_DOM'(1);
            r_dom_idx   <= '0;
            r_gap_cnt   <= GAP_LD;
          end else begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
          end
        end
        ST_RELEASE: begin
          if (r_dom_idx == LAST_DOM) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b0;
            r_rdc_qlfy <= 1'b0;
          end else if (r_gap_cnt == '0) begin
            r_dom_idx              <= w_idx_nxt;
            r_dom_rst_n[w_idx_nxt] <= 1'b1;
            r_gap_cnt              <= GAP_LD;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        ST_RUN: ;
        default: begin
          r_state     <= ST_ASSERT;
          r_hold_cnt  <= HOLD_LD;
          r_dom_rst_n <= '0;
          r_busy      <= 1'b1;
          r_rdc_qlfy  <= 1'b1;
        end
      endcase
    end
  end

  assign dom_rst_n_o = r_dom_rst_n;
  assign busy_o      = r_busy;
  assign rdc_qlfy_o  = r_rdc_qlfy;

`ifdef SCR1_RST_SEQ_CAUSE_EN
  logic [N_SRC:0] r_cause;

  // Clear applies only in RUN; a request on the same edge still leaves its bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause <= {{N_SRC{1'b0}}, 1'b1};
    end else begin
      r_cause <= (((cause_clr_i && (r_state == ST_RUN)) ? '0 : r_cause) | {w_req_vec, 1'b0});
    end
  end

  assign cause_o = r_cause;
`else
  logic w_unused_cause_clr;
  assign w_unused_cause_clr = cause_clr_i;
  assign cause_o            = '0;
`endif

endmodule

// File: tb/tb_scr1_rst_seq.sv
// Self-checking bench for scr1_rst_seq; reference model counts quiet edges since the last reset event.
module tb_scr1_rst_seq;

  localparam int N_SRC = 2;
  localparam int N_DOM = 3;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_SRC-1:0] rst_req_i = '0;
  logic [N_SRC-1:0] rst_req_mask_i = '0;
  logic             cause_clr_i = 1'b0;
  logic [N_DOM-1:0] dom_rst_n_o;
  logic             rdc_qlfy_o;
  logic             busy_o;
  logic [N_SRC:0]   cause_o;

  int n_total = 0;
  int n_pass  = 0;

  // Model: number of consecutive edges with rst=0 and no unmasked request.
  int             m_quiet = 0;
  logic [N_SRC:0] m_cause = '0;

  scr1_rst_seq #(
    .N_SRC(N_SRC), .N_DOM(N_DOM), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_req_i      (rst_req_i),
    .rst_req_mask_i (rst_req_mask_i),
    .dom_rst_n_o    (dom_rst_n_o),
    .rdc_qlfy_o     (rdc_qlfy_o),
    .busy_o         (busy_o),
    .cause_clr_i    (cause_clr_i),
    .cause_o        (cause_o)
  );

  always #5 clk = ~clk;

  function automatic logic exp_busy();
    return m_quiet < (HOLD + (N_DOM - 1) * GAP + 1);
  endfunction

  function automatic logic [N_DOM+1:0] exp_vec();
    logic [N_DOM-1:0] d;
    for (int k = 0; k < N_DOM; k++) d[k] = (m_quiet >= HOLD + k * GAP);
    return {d, exp_busy(), exp_busy()};
  endfunction

  function automatic logic [N_SRC:0] exp_cause();
`ifdef SCR1_RST_SEQ_CAUSE_EN
    return m_cause;
`else
    return '0;
`endif
  endfunction

  // Advance one edge: update the model from the inputs seen at that edge, then sample #1 later.
  task automatic step();
    logic [N_SRC-1:0] eff;
    eff = rst_req_i & ~rst_req_mask_i;
    if (rst) begin
      m_quiet = 0;
      m_cause = {{N_SRC{1'b0}}, 1'b1};
    end else begin
      if (cause_clr_i && !exp_busy()) m_cause = '0;
      m_cause = m_cause | {eff, 1'b0};
      if (|eff) m_quiet = 0;
      else if (m_quiet < 10000) m_quiet = m_quiet + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int guard = 0;
    rst_req_i = '0; rst_req_mask_i = '0; cause_clr_i = 1'b0;
    while (exp_busy() && guard < 100) begin step(); guard++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++;
      if ({dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o} !== {exp_vec(), exp_cause()})
        $display("FAIL reset cyc %0d: got dom/busy/rdc/cause %b want %b", c,
                 {dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o}, {exp_vec(), exp_cause()});
      else n_pass++;
    end
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_total++;
      if ({dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o} !== {exp_vec(), exp_cause()})
        $display("FAIL powerup edge %0d: got dom/busy/rdc/cause %b want %b", c,
                 {dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o}, {exp_vec(), exp_cause()});
      else n_pass++;
    end
  endtask

  task automatic test_pulse();
    settle();
    rst_req_i = 2'b10;
    step();
    rst_req_i = 2'b00;
    n_total++;
    if (dom_rst_n_o !== 3'b000 || busy_o !== 1'b1)
      $display("FAIL pulse latency: got dom %b busy %b want dom 000 busy 1", dom_rst_n_o, busy_o);
    else n_pass++;
    for (int c = 1; c <= 11; c++) begin
      step();
      n_total++;
      if ({dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o} !== {exp_vec(), exp_cause()})
        $display("FAIL pulse edge %0d: got %b want %b", c,
                 {dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o}, {exp_vec(), exp_cause()});
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    settle();
    rst_req_i = 2'b01;
    for (int c = 0; c < 10; c++) begin
      step();
      n_total++;
      if (dom_rst_n_o !== 3'b000 || busy_o !== 1'b1)
        $display("FAIL hold held cyc %0d: got dom %b busy %b want 000 1", c, dom_rst_n_o, busy_o);
      else n_pass++;
    end
    rst_req_i = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_total++;
      if ({dom_rst_n_o, busy_o, rdc_qlfy_o} !== exp_vec())
        $display("FAIL hold release edge %0d: got %b want %b", c,
                 {dom_rst_n_o, busy_o, rdc_qlfy_o}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    settle();
    rst_req_i = 2'b10;
    step();
    rst_req_i = 2'b00;
    for (int c = 0; c < HOLD + GAP; c++) step();
    n_total++;
    if (dom_rst_n_o !== 3'b011)
      $display("FAIL abort pre: got dom %b want 011", dom_rst_n_o);
    else n_pass++;
    rst_req_i = 2'b01;
    step();
    rst_req_i = 2'b00;
    n_total++;
    if ({dom_rst_n_o, busy_o, rdc_qlfy_o} !== {3'b000, 2'b11})
      $display("FAIL abort reassert: got %b want 00011", {dom_rst_n_o, busy_o, rdc_qlfy_o});
    else n_pass++;
    // Request landing on the edge that would release the last domain.
    for (int c = 0; c < HOLD + 2 * GAP - 1; c++) step();
    rst_req_i = 2'b10;
    step();
    rst_req_i = 2'b00;
    n_total++;
    if ({dom_rst_n_o, busy_o, rdc_qlfy_o} !== exp_vec() || dom_rst_n_o !== 3'b000)
      $display("FAIL abort final: got %b want %b", {dom_rst_n_o, busy_o, rdc_qlfy_o}, exp_vec());
    else n_pass++;
  endtask

  task automatic test_mask();
    settle();
    rst_req_mask_i = 2'b01;
    rst_req_i      = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      n_total++;
      if (busy_o !== 1'b0 || dom_rst_n_o !== 3'b111)
        $display("FAIL mask masked cyc %0d: got busy %b dom %b want 0 111", c, busy_o, dom_rst_n_o);
      else n_pass++;
    end
    rst_req_mask_i = 2'b00;
    step();
    n_total++;
    if (busy_o !== 1'b1 || dom_rst_n_o !== 3'b000)
      $display("FAIL mask unmask: got busy %b dom %b want 1 000", busy_o, dom_rst_n_o);
    else n_pass++;
    // Masking mid-hold stops extension: release then follows the quiet-edge count.
    step();
    rst_req_mask_i = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      step();
      n_total++;
      if ({dom_rst_n_o, busy_o, rdc_qlfy_o} !== exp_vec())
        $display("FAIL mask midhold edge %0d: got %b want %b", c,
                 {dom_rst_n_o, busy_o, rdc_qlfy_o}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_cause();
    settle();
    cause_clr_i = 1'b1;
    step();
    cause_clr_i = 1'b0;
    n_total++;
    if (cause_o !== exp_cause() || cause_o !== 3'b000)
      $display("FAIL cause clear: got %b want 000", cause_o);
    else n_pass++;
    cause_clr_i = 1'b1;
    rst_req_i   = 2'b10;
    step();
    cause_clr_i = 1'b0;
    rst_req_i   = 2'b00;
    n_total++;
    if (cause_o !== exp_cause())
      $display("FAIL cause clr+req: got %b want %b", cause_o, exp_cause());
    else n_pass++;
    cause_clr_i = 1'b1;
    step();
    cause_clr_i = 1'b0;
    n_total++;
    if (cause_o !== exp_cause())
      $display("FAIL cause clr busy: got %b want %b", cause_o, exp_cause());
    else n_pass++;
  endtask

  task automatic test_random();
    settle();
    for (int c = 0; c < 400; c++) begin
      rst_req_i      = ($urandom_range(0, 9) == 0) ? N_SRC'($urandom) : '0;
      rst_req_mask_i = ($urandom_range(0, 3) == 0) ? N_SRC'($urandom) : '0;
      cause_clr_i    = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 99) == 0);
      step();
      n_total++;
      if ({dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o} !== {exp_vec(), exp_cause()})
        $display("FAIL random cyc %0d: got %b want %b", c,
                 {dom_rst_n_o, busy_o, rdc_qlfy_o, cause_o}, {exp_vec(), exp_cause()});
      else n_pass++;
      n_total++;
      if (((dom_rst_n_o >> 1) & ~dom_rst_n_o) !== '0)
        $display("FAIL random monotonic cyc %0d: got dom %b", c, dom_rst_n_o);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_hold();
    test_abort();
    test_mask();
    test_cause();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
